// File: rtl/int_ctrl_ahb_if.sv
// AHB-Lite slave front end for the interrupt controller register block.
// Turns AHB address/data-phase transfers into single-cycle register strobes.
// Reads take one wait state. Misaligned or oversized transfers get a
// two-cycle ERROR response and never reach the register file.
module int_ctrl_ahb_if #(
    parameter int ADDRWIDTH = 12
) (
    input  logic                 hclk,
    input  logic                 hreset,
    input  logic                 hsels,
    input  logic [ADDRWIDTH-1:0] haddrs,
    input  logic [1:0]           htranss,
    input  logic [2:0]           hsizes,
    input  logic                 hwrites,
    input  logic                 hreadys,
    input  logic [31:0]          hwdatas,
    output logic                 hreadyouts,
    output logic                 hresps,
    output logic [31:0]          hrdatas,
    output logic [ADDRWIDTH-1:0] addr,
    output logic                 read_en,
    output logic                 write_en,
    output logic [3:0]           byte_strobe,
    output logic [31:0]          wdata,
    input  logic [31:0]          rdata
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_WAIT,
        RD_DONE,
        ERR1,
        ERR2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       accept;
    logic       legal;
    logic [3:0] mask;

    // A transfer is taken only when this slave is ready, so a pending data
    // phase with wait states can never be overlapped by a new address phase.
    assign accept = hsels & hreadys & htranss[1] & hreadyouts;

    // Size/alignment legality and byte-lane mask of the current address phase.
    always_comb begin
        legal = 1'b0;
        mask  = 4'b0000;
        case (hsizes)
            3'd0: begin
                legal = 1'b1;
                mask  = 4'b0001 << haddrs[1:0];
            end
            3'd1: begin
                legal = ~haddrs[0];
                mask  = haddrs[1] ? 4'b1100 : 4'b0011;
            end
            3'd2: begin
                legal = (haddrs[1:0] == 2'b00);
                mask  = 4'b1111;
            end
            default: begin
                legal = 1'b0;
                mask  = 4'b0000;
            end
        endcase
        if (!legal) begin
            mask = 4'b0000;
        end
    end

    // State register.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection and per-state bus/strobe outputs.
    always_comb begin
        state_next = state;
        hreadyouts = 1'b1;
        hresps     = 1'b0;
        read_en    = 1'b0;
        write_en   = 1'b0;
        wdata      = 32'd0;
        case (state)
            RD_WAIT: begin
                read_en    = 1'b1;
                hreadyouts = 1'b0;
                state_next = RD_DONE;
            end
            ERR1: begin
                hresps     = 1'b1;
                hreadyouts = 1'b0;
                state_next = ERR2;
            end
            default: begin
                if (state == WRITE) begin
                    write_en = 1'b1;
                    wdata    = hwdatas;
                end
                if (state == ERR2) begin
                    hresps = 1'b1;
                end
                if (accept) begin
                    if (!legal) begin
                        state_next = ERR1;
                    end else if (hwrites) begin
                        state_next = WRITE;
                    end else begin
                        state_next = RD_WAIT;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    // Register address and byte lanes of the accepted transfer; held until the next accept.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            addr        <= '0;
            byte_strobe <= 4'b0000;
        end else if (accept) begin
            addr        <= {haddrs[ADDRWIDTH-1:2], 2'b00};
            byte_strobe <= mask;
        end
    end

    // Capture register read data at the end of the wait-state cycle.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            hrdatas <= 32'd0;
        end else if (state == RD_WAIT) begin
            hrdatas <= rdata;
        end
    end

endmodule

// File: tb/tb_int_ctrl_ahb_if.sv
// Scoreboard testbench for int_ctrl_ahb_if with a small register block model.
module tb_int_ctrl_ahb_if;

    localparam int AW = 12;

    localparam int K_WR  = 0;
    localparam int K_RD  = 1;
    localparam int K_ERR = 2;

    typedef struct {
        int          kind;
        logic [11:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
    } exp_t;

    logic          hclk;
    logic          hreset;
    logic          hsels;
    logic [AW-1:0] haddrs;
    logic [1:0]    htranss;
    logic [2:0]    hsizes;
    logic          hwrites;
    logic          hreadys;
    logic [31:0]   hwdatas;
    logic          hreadyouts;
    logic          hresps;
    logic [31:0]   hrdatas;
    logic [AW-1:0] addr;
    logic          read_en;
    logic          write_en;
    logic [3:0]    byte_strobe;
    logic [31:0]   wdata;
    logic [31:0]   rdata;

    logic [3:0]    ecorevnum;
    logic [31:0]   mem [0:1023];

    exp_t exp_q[$];
    int   checks;
    int   errors;
    bit   dp_active;

    int_ctrl_ahb_if #(.ADDRWIDTH(AW)) dut (
        .hclk        (hclk),
        .hreset      (hreset),
        .hsels       (hsels),
        .haddrs      (haddrs),
        .htranss     (htranss),
        .hsizes      (hsizes),
        .hwrites     (hwrites),
        .hreadys     (hreadys),
        .hwdatas     (hwdatas),
        .hreadyouts  (hreadyouts),
        .hresps      (hresps),
        .hrdatas     (hrdatas),
        .addr        (addr),
        .read_en     (read_en),
        .write_en    (write_en),
        .byte_strobe (byte_strobe),
        .wdata       (wdata),
        .rdata       (rdata)
    );

    // Single slave on the bus, so the bus-wide ready is this slave's ready.
    assign hreadys = hreadyouts;

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // Register block model: plain storage plus two read-only ID registers.
    always_comb begin
        rdata = mem[addr[11:2]];
        if (addr == 12'hFE0) begin
            rdata = 32'h0000_0017;
        end else if (addr == 12'hFEC) begin
            rdata = {24'd0, ecorevnum, 4'd0};
        end
    end

    // Byte-lane writes into the register block model.
    always @(posedge hclk) begin
        if (write_en) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_strobe[b]) begin
                    mem[addr[11:2]][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Issue one address phase and hold it until accepted; drive write data in the data phase.
    task automatic applyStimulus(input logic wr, input logic [11:0] a, input logic [2:0] sz,
                                 input logic [31:0] wd, input int kind,
                                 input logic [11:0] exp_addr, input logic [3:0] exp_strobe,
                                 input logic [31:0] exp_data);
        exp_t e;
        int   n;
        e.kind   = kind;
        e.addr   = exp_addr;
        e.strobe = exp_strobe;
        e.data   = exp_data;
        exp_q.push_back(e);
        hsels   = 1'b1;
        htranss = 2'b10;
        haddrs  = a;
        hsizes  = sz;
        hwrites = wr;
        n = 0;
        do begin
            @(negedge hclk);
            n++;
        end while (!hreadyouts && n < 10);
        if (!hreadyouts) begin
            errors++;
            $display("[TB] FAIL accept_timeout actual=%0h expected=%0h", hreadyouts, 1'b1);
        end
        @(posedge hclk);
        #1;
        hwdatas = wr ? wd : 32'd0;
        hsels   = 1'b0;
        htranss = 2'b00;
        hwrites = 1'b0;
    endtask

    // Hold the bus in a non-transfer pattern for a few cycles.
    task automatic idleCycles(input logic sel, input logic [1:0] trans, input int n);
        hsels   = sel;
        htranss = trans;
        haddrs  = 12'h000;
        hsizes  = 3'd2;
        hwrites = 1'b1;
        repeat (n) @(posedge hclk);
        #1;
        hsels   = 1'b0;
        htranss = 2'b00;
        hwrites = 1'b0;
    endtask

    // Monitor: checks reset values, idle cycles, and each data phase against the queue head.
    initial begin
        exp_t        cur;
        int          cyc;
        logic [31:0] last_rd;
        dp_active = 1'b0;
        cyc       = 0;
        last_rd   = 32'd0;
        forever begin
            @(negedge hclk);
            if (hreset) begin
                if (dp_active && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                end
                dp_active = 1'b0;
                last_rd   = 32'd0;
                checkOutput("rst_hreadyouts", {31'd0, hreadyouts}, 32'd1);
                checkOutput("rst_hresps", {31'd0, hresps}, 32'd0);
                checkOutput("rst_hrdatas", hrdatas, 32'd0);
                checkOutput("rst_addr", {20'd0, addr}, 32'd0);
                checkOutput("rst_strobes", {30'd0, read_en, write_en}, 32'd0);
                checkOutput("rst_byte_strobe", {28'd0, byte_strobe}, 32'd0);
                checkOutput("rst_wdata", wdata, 32'd0);
            end else begin
                if (dp_active) begin
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_phase actual=%0h expected=%0h", 1, 0);
                        dp_active = 1'b0;
                    end else begin
                        cur = exp_q[0];
                        case (cur.kind)
                            K_WR: begin
                                checkOutput("wr_hreadyouts", {31'd0, hreadyouts}, 32'd1);
                                checkOutput("wr_strobes", {30'd0, read_en, write_en}, 32'd1);
                                checkOutput("wr_hresps", {31'd0, hresps}, 32'd0);
                                checkOutput("wr_addr", {20'd0, addr}, {20'd0, cur.addr});
                                checkOutput("wr_byte_strobe", {28'd0, byte_strobe}, {28'd0, cur.strobe});
                                checkOutput("wr_wdata", wdata, cur.data);
                                checkOutput("wr_hrdatas_hold", hrdatas, last_rd);
                            end
                            K_RD: begin
                                if (cyc == 0) begin
                                    checkOutput("rd_wait_hreadyouts", {31'd0, hreadyouts}, 32'd0);
                                    checkOutput("rd_wait_strobes", {30'd0, read_en, write_en}, 32'd2);
                                    checkOutput("rd_addr", {20'd0, addr}, {20'd0, cur.addr});
                                    checkOutput("rd_byte_strobe", {28'd0, byte_strobe}, {28'd0, cur.strobe});
                                end else begin
                                    checkOutput("rd_done_hreadyouts", {31'd0, hreadyouts}, 32'd1);
                                    checkOutput("rd_done_strobes", {30'd0, read_en, write_en}, 32'd0);
                                    checkOutput("rd_hresps", {31'd0, hresps}, 32'd0);
                                    checkOutput("rd_hrdatas", hrdatas, cur.data);
                                    last_rd = cur.data;
                                end
                            end
                            default: begin
                                checkOutput("err_hresps", {31'd0, hresps}, 32'd1);
                                checkOutput("err_strobes", {30'd0, read_en, write_en}, 32'd0);
                                checkOutput("err_hreadyouts", {31'd0, hreadyouts}, (cyc == 0) ? 32'd0 : 32'd1);
                            end
                        endcase
                        cyc++;
                        if (hreadyouts) begin
                            void'(exp_q.pop_front());
                            dp_active = 1'b0;
                        end else if (cyc > 4) begin
                            errors++;
                            $display("[TB] FAIL phase_timeout actual=%0h expected=%0h", hreadyouts, 1'b1);
                            void'(exp_q.pop_front());
                            dp_active = 1'b0;
                        end
                    end
                end else begin
                    checkOutput("idle_strobes", {30'd0, read_en, write_en}, 32'd0);
                    checkOutput("idle_hresps", {31'd0, hresps}, 32'd0);
                    checkOutput("idle_hreadyouts", {31'd0, hreadyouts}, 32'd1);
                end
                if (hsels && htranss[1] && hreadyouts) begin
                    dp_active = 1'b1;
                    cyc       = 0;
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        int n;
        checks    = 0;
        errors    = 0;
        ecorevnum = 4'd0;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 32'd0;
        end
        hreset  = 1'b1;
        hsels   = 1'b0;
        haddrs  = '0;
        htranss = 2'b00;
        hsizes  = 3'd0;
        hwrites = 1'b0;
        hwdatas = 32'd0;
        repeat (2) @(posedge hclk);
        #1;
        hreset = 1'b0;
        @(posedge hclk);
        #1;

        $display("[TB] word write then read back");
        applyStimulus(1'b1, 12'h000, 3'd2, 32'hA5A5_0001, K_WR, 12'h000, 4'b1111, 32'hA5A5_0001);
        applyStimulus(1'b0, 12'h000, 3'd2, 32'd0,        K_RD, 12'h000, 4'b1111, 32'hA5A5_0001);

        $display("[TB] byte and half writes");
        applyStimulus(1'b1, 12'h004, 3'd2, 32'h1122_3344, K_WR, 12'h004, 4'b1111, 32'h1122_3344);
        applyStimulus(1'b1, 12'h005, 3'd0, 32'h0000_7700, K_WR, 12'h004, 4'b0010, 32'h0000_7700);
        applyStimulus(1'b1, 12'h00A, 3'd1, 32'hBEEF_0000, K_WR, 12'h008, 4'b1100, 32'hBEEF_0000);
        applyStimulus(1'b0, 12'h004, 3'd2, 32'd0,         K_RD, 12'h004, 4'b1111, 32'h1122_7744);
        applyStimulus(1'b0, 12'h008, 3'd2, 32'd0,         K_RD, 12'h008, 4'b1111, 32'hBEEF_0000);

        $display("[TB] back-to-back writes then read");
        applyStimulus(1'b1, 12'h008, 3'd2, 32'h1234_5678, K_WR, 12'h008, 4'b1111, 32'h1234_5678);
        applyStimulus(1'b1, 12'h00C, 3'd2, 32'h9ABC_DEF0, K_WR, 12'h00C, 4'b1111, 32'h9ABC_DEF0);
        applyStimulus(1'b0, 12'h008, 3'd2, 32'd0,         K_RD, 12'h008, 4'b1111, 32'h1234_5678);

        $display("[TB] non-transfer bus patterns");
        idleCycles(1'b0, 2'b10, 2);
        idleCycles(1'b1, 2'b01, 2);

        $display("[TB] illegal transfers");
        applyStimulus(1'b0, 12'h002, 3'd2, 32'd0,         K_ERR, 12'h000, 4'b0000, 32'd0);
        applyStimulus(1'b1, 12'h003, 3'd1, 32'hDEAD_BEEF, K_ERR, 12'h000, 4'b0000, 32'd0);
        applyStimulus(1'b1, 12'h000, 3'd3, 32'hDEAD_BEEF, K_ERR, 12'h000, 4'b0000, 32'd0);

        $display("[TB] narrow reads");
        applyStimulus(1'b0, 12'h00F, 3'd0, 32'd0, K_RD, 12'h00C, 4'b1000, 32'h9ABC_DEF0);
        applyStimulus(1'b0, 12'h002, 3'd1, 32'd0, K_RD, 12'h000, 4'b1100, 32'hA5A5_0001);

        $display("[TB] ID register reads");
        applyStimulus(1'b0, 12'hFE0, 3'd2, 32'd0, K_RD, 12'hFE0, 4'b1111, 32'h0000_0017);
        ecorevnum = 4'd3;
        applyStimulus(1'b0, 12'hFEC, 3'd2, 32'd0, K_RD, 12'hFEC, 4'b1111, 32'h0000_0030);

        $display("[TB] reset during read wait state");
        applyStimulus(1'b0, 12'h000, 3'd2, 32'd0, K_RD, 12'h000, 4'b1111, 32'hA5A5_0001);
        hreset = 1'b1;
        @(posedge hclk);
        #1;
        hreset = 1'b0;
        @(posedge hclk);
        #1;
        applyStimulus(1'b1, 12'h010, 3'd2, 32'hCAFE_F00D, K_WR, 12'h010, 4'b1111, 32'hCAFE_F00D);
        applyStimulus(1'b0, 12'h010, 3'd2, 32'd0,         K_RD, 12'h010, 4'b1111, 32'hCAFE_F00D);

        n = 0;
        while ((exp_q.size() != 0 || dp_active) && n < 20) begin
            @(posedge hclk);
            n++;
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_timeout actual=%0d expected=%0d", exp_q.size(), 0);
        end
        repeat (2) @(posedge hclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
